// File: rtl/traffic_pkg.sv
// Shared types and lamp codes for the intersection phase sequencer.
// State encodings are visible on the debug port, so keep them fixed.
package traffic_pkg;

    typedef enum logic [2:0] {
        ALLRED_A    = 3'd0,
        MAIN_GREEN  = 3'd1,
        MAIN_YELLOW = 3'd2,
        ALLRED_B    = 3'd3,
        WALK        = 3'd4,
        SIDE_GREEN  = 3'd5,
        SIDE_YELLOW = 3'd6
    } state_t;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

endpackage

// File: rtl/phase_timer.sv
// Dwell timer: counts from 0 after each restart; exp marks the last cycle.
// With hold set it parks on dur-1 so exp stays high until a restart.
module phase_timer #(
    parameter int TW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          restart,
    input  logic [TW-1:0] dur,
    input  logic          hold,
    output logic          exp
);

    logic [TW-1:0] count;

    assign exp = (count == (dur - TW'(1)));

    // Count register: cleared on state change, frozen at dur-1 while held.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (restart) begin
            count <= '0;
        end else if (!(hold && exp)) begin
            count <= count + TW'(1);
        end
    end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection sequencer with pedestrian phase.
// Main road rests in green; side/ped demands are latched and served in turn.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int TW           = 16,
    parameter int T_ALL_RED    = 2,
    parameter int T_MAIN_GREEN = 8,
    parameter int T_YELLOW     = 3,
    parameter int T_SIDE_GREEN = 5,
    parameter int T_WALK       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       side_car,
    input  logic       ped_req,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk,
    output logic       ped_wait,
    output logic [2:0] state_o
);

    state_t        state;
    state_t        state_nx;
    logic          car_q;
    logic          ped_q;
    logic          exp;
    logic          restart;
    logic          hold;
    logic          enter_side;
    logic          enter_walk;
    logic [TW-1:0] dur;

    // Dwell length for the current state.
    always_comb begin
        dur = TW'(T_ALL_RED);
        unique case (state)
            ALLRED_A:    dur = TW'(T_ALL_RED);
            MAIN_GREEN:  dur = TW'(T_MAIN_GREEN);
            MAIN_YELLOW: dur = TW'(T_YELLOW);
            ALLRED_B:    dur = TW'(T_ALL_RED);
            WALK:        dur = TW'(T_WALK);
            SIDE_GREEN:  dur = TW'(T_SIDE_GREEN);
            SIDE_YELLOW: dur = TW'(T_YELLOW);
            default:     dur = TW'(T_ALL_RED);
        endcase
    end

    phase_timer #(
        .TW (TW)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .dur     (dur),
        .hold    (hold),
        .exp     (exp)
    );

    // Next-state logic; any unknown encoding falls back to all-red.
    always_comb begin
        state_nx = state;
        unique case (state)
            ALLRED_A:    if (exp) state_nx = MAIN_GREEN;
            MAIN_GREEN:  if (exp && (car_q || ped_q)) state_nx = MAIN_YELLOW;
            MAIN_YELLOW: if (exp) state_nx = ALLRED_B;
            ALLRED_B:    if (exp) state_nx = ped_q ? WALK : SIDE_GREEN;
            WALK:        if (exp) state_nx = car_q ? SIDE_GREEN : ALLRED_A;
            SIDE_GREEN:  if (exp) state_nx = SIDE_YELLOW;
            SIDE_YELLOW: if (exp) state_nx = ALLRED_A;
            default:     state_nx = ALLRED_A;
        endcase
    end

    assign restart    = (state_nx != state);
    assign hold       = (state == MAIN_GREEN);
    assign enter_side = (state_nx == SIDE_GREEN) && (state != SIDE_GREEN);
    assign enter_walk = (state_nx == WALK) && (state != WALK);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ALLRED_A;
        end else begin
            state <= state_nx;
        end
    end

    // Demand latches; serving a phase wins over a same-cycle request.
    always_ff @(posedge clk) begin
        if (reset) begin
            car_q <= 1'b0;
            ped_q <= 1'b0;
        end else begin
            if (enter_side) begin
                car_q <= 1'b0;
            end else if (side_car) begin
                car_q <= 1'b1;
            end
            if (enter_walk) begin
                ped_q <= 1'b0;
            end else if (ped_req) begin
                ped_q <= 1'b1;
            end
        end
    end

    // Lamp decode from the state register only.
    always_comb begin
        main_light = LAMP_RED;
        side_light = LAMP_RED;
        walk       = 1'b0;
        unique case (state)
            MAIN_GREEN:  main_light = LAMP_GRN;
            MAIN_YELLOW: main_light = LAMP_YEL;
            SIDE_GREEN:  side_light = LAMP_GRN;
            SIDE_YELLOW: side_light = LAMP_YEL;
            WALK:        walk       = 1'b1;
            default:     walk       = 1'b0;
        endcase
    end

    assign ped_wait = ped_q;
    assign state_o  = state;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench for traffic_phase_ctrl: expected per-cycle states are
// queued by the stimulus and checked by an independent monitor.
module tb_traffic_phase_ctrl;
    import traffic_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       side_car;
    logic       ped_req;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk;
    logic       ped_wait;
    logic [2:0] state_o;

    typedef struct {
        state_t st;
        logic   pw;
        int     cyc;
    } exp_t;

    exp_t  sb[$];
    exp_t  e;
    int    n_tests = 0;
    int    n_fail  = 0;
    int    push_c  = 0;
    string scn     = "reset";

    traffic_phase_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .side_car   (side_car),
        .ped_req    (ped_req),
        .main_light (main_light),
        .side_light (side_light),
        .walk       (walk),
        .ped_wait   (ped_wait),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] m_lamp(state_t s);
        if (s == MAIN_GREEN)  return LAMP_GRN;
        if (s == MAIN_YELLOW) return LAMP_YEL;
        return LAMP_RED;
    endfunction

    function automatic logic [2:0] s_lamp(state_t s);
        if (s == SIDE_GREEN)  return LAMP_GRN;
        if (s == SIDE_YELLOW) return LAMP_YEL;
        return LAMP_RED;
    endfunction

    // Monitor: one expected entry per cycle while the queue holds any.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            if (state_o !== 3'(e.st) || main_light !== m_lamp(e.st) ||
                side_light !== s_lamp(e.st) ||
                walk !== (e.st == WALK) || ped_wait !== e.pw) begin
                n_fail++;
                $display("FAIL %s c%0d: got st=%0d m=%b s=%b w=%b pw=%b, want st=%0d m=%b s=%b w=%b pw=%b",
                         scn, e.cyc, state_o, main_light, side_light, walk,
                         ped_wait, 3'(e.st), m_lamp(e.st), s_lamp(e.st),
                         (e.st == WALK), e.pw);
            end
        end
    end

    // Safety invariant, every cycle.
    always @(negedge clk) begin
        logic mnr;
        logic snr;
        mnr = (main_light !== LAMP_RED);
        snr = (side_light !== LAMP_RED);
        n_tests++;
        if ((mnr && snr) || (walk !== 1'b0 && (mnr || snr))) begin
            n_fail++;
            $display("FAIL safety %s: m=%b s=%b w=%b", scn, main_light,
                     side_light, walk);
        end
    end

    task automatic push(state_t s, int n, logic pw);
        for (int i = 0; i < n; i++) begin
            exp_t x;
            x.st  = s;
            x.pw  = pw;
            x.cyc = push_c;
            sb.push_back(x);
            push_c++;
        end
    endtask

    task automatic start_scn(string name);
        reset    = 1'b1;
        side_car = 1'b0;
        ped_req  = 1'b0;
        @(posedge clk);
        #1;
        reset  = 1'b0;
        scn    = name;
        push_c = 0;
    endtask

    // Drive n cycles; pulses at the given cycle indices (-1 = unused).
    task automatic run(int n, int car_a, int car_b, int ped_a, int ped_b,
                       int rst_c);
        for (int c = 0; c < n; c++) begin
            side_car = (c == car_a) || (c == car_b);
            ped_req  = (c == ped_a) || (c == ped_b);
            reset    = (c == rst_c);
            @(posedge clk);
            #1;
        end
        side_car = 1'b0;
        ped_req  = 1'b0;
        reset    = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        side_car = 1'b0;
        ped_req  = 1'b0;
        @(posedge clk);
        #1;

        start_scn("idle");
        push(ALLRED_A, 2, 0);
        push(MAIN_GREEN, 1000, 0);
        run(1002, -1, -1, -1, -1, -1);

        start_scn("side");
        push(ALLRED_A, 2, 0);
        push(MAIN_GREEN, 8, 0);
        push(MAIN_YELLOW, 3, 0);
        push(ALLRED_B, 2, 0);
        push(SIDE_GREEN, 5, 0);
        push(SIDE_YELLOW, 3, 0);
        push(ALLRED_A, 2, 0);
        push(MAIN_GREEN, 10, 0);
        run(35, 4, -1, -1, -1, -1);

        start_scn("ped");
        push(ALLRED_A, 2, 0);
        push(MAIN_GREEN, 3, 0);
        push(MAIN_GREEN, 5, 1);
        push(MAIN_YELLOW, 3, 1);
        push(ALLRED_B, 2, 1);
        push(WALK, 4, 0);
        push(ALLRED_A, 2, 0);
        push(MAIN_GREEN, 10, 0);
        run(31, -1, -1, 4, 14, -1);

        start_scn("both");
        push(ALLRED_A, 2, 0);
        push(MAIN_GREEN, 3, 0);
        push(MAIN_GREEN, 5, 1);
        push(MAIN_YELLOW, 3, 1);
        push(ALLRED_B, 2, 1);
        push(WALK, 4, 0);
        push(SIDE_GREEN, 5, 0);
        push(SIDE_YELLOW, 3, 0);
        push(ALLRED_A, 2, 0);
        push(MAIN_GREEN, 8, 0);
        push(MAIN_YELLOW, 3, 0);
        push(ALLRED_B, 2, 0);
        push(SIDE_GREEN, 5, 0);
        push(SIDE_YELLOW, 3, 0);
        push(ALLRED_A, 2, 0);
        push(MAIN_GREEN, 3, 0);
        run(55, 4, 20, 4, -1, -1);

        start_scn("late");
        push(ALLRED_A, 2, 0);
        push(MAIN_GREEN, 21, 0);
        push(MAIN_YELLOW, 3, 0);
        push(ALLRED_B, 2, 0);
        push(SIDE_GREEN, 5, 0);
        push(SIDE_YELLOW, 3, 0);
        push(ALLRED_A, 2, 0);
        push(MAIN_GREEN, 3, 0);
        run(41, 21, -1, -1, -1, -1);

        start_scn("rst_walk");
        push(ALLRED_A, 2, 0);
        push(MAIN_GREEN, 3, 0);
        push(MAIN_GREEN, 5, 1);
        push(MAIN_YELLOW, 3, 1);
        push(ALLRED_B, 2, 1);
        push(WALK, 2, 0);
        push(ALLRED_A, 2, 0);
        push(MAIN_GREEN, 3, 0);
        run(22, -1, -1, 4, -1, 16);

        @(negedge clk);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
